// File: rtl/fir_decim_buffer.sv
// fir_decim_buffer: accumulate-and-dump decimator for the FIR output stream,
// followed by a small first-word-fall-through FIFO with valid/ready output
// and a sticky overflow flag for results dropped while the queue is full.
module fir_decim_buffer #(
  parameter int DW    = 8,
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DW-1:0]     y_in,
  input  logic                     in_en,
  output logic signed [DW-1:0]     dec_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int LW = $clog2(DECIM);
  localparam int AW = DW + LW;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [LW-1:0] PH_LAST  = LW'(DECIM - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic signed [AW-1:0] acc;
  logic        [LW-1:0] ph;
  logic signed [AW-1:0] y_ext;
  logic signed [AW-1:0] sum;
  logic signed [DW-1:0] push_data;
  logic                 last;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 push_ok;

  logic signed [DW-1:0] mem [DEPTH];
  logic        [PW-1:0] wptr;
  logic        [PW-1:0] rptr;

  // Datapath and handshake decode; the dumped average is the sum with its
  // low log2(DECIM) bits dropped, i.e. an arithmetic shift right.
  always_comb begin
    y_ext     = {{LW{y_in[DW-1]}}, y_in};
    sum       = acc + y_ext;
    push_data = sum[AW-1:LW];
    last      = (ph == PH_LAST);
    push      = in_en && last;
    out_valid = (fifo_count != '0);
    pop       = out_valid && out_ready;
    full      = (fifo_count == FULL_CNT);
    push_ok   = push && (!full || pop);
    dec_out   = out_valid ? mem[rptr] : '0;
  end

  // Accumulator and phase counter; both hold while in_en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      ph  <= '0;
    end else if (in_en) begin
      if (last) begin
        acc <= '0;
        ph  <= '0;
      end else begin
        acc <= sum;
        ph  <= ph + LW'(1);
      end
    end
  end

  // FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Self-checking bench for fir_decim_buffer: directed test-plan scenarios plus
// a randomized run, all checked against a queue-based reference model.
module tb_fir_decim_buffer;

  localparam int DW    = 8;
  localparam int DECIM = 4;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic signed [DW-1:0] y_in = '0;
  logic                 in_en = 1'b0;
  logic signed [DW-1:0] dec_out;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                 overflow;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int q[$];
  int m_sum = 0;
  int m_n = 0;
  bit m_ovf = 1'b0;

  fir_decim_buffer #(.DW(DW), .DECIM(DECIM), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .y_in       (y_in),
    .in_en      (in_en),
    .dec_out    (dec_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  function automatic int floor_div(input int s);
    int r;
    r = s / DECIM;
    if ((s % DECIM) != 0 && s < 0) r = r - 1;
    return r;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int e_dec;
    e_dec = (q.size() != 0) ? q[0] : 0;
    check("valid", out_valid, (q.size() != 0) ? 1 : 0);
    check("dec_out", dec_out, e_dec);
    check("count", fifo_count, q.size());
    check("overflow", overflow, m_ovf ? 1 : 0);
  endtask

  // One clock cycle: drive inputs, check current outputs, clock, update model.
  task automatic cycle(input bit rst, input bit en, input int y, input bit rdy);
    bit popd;
    reset     = rst;
    in_en     = en;
    y_in      = DW'(y);
    out_ready = rdy;
    check_model();
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_sum = 0;
      m_n   = 0;
      m_ovf = 1'b0;
    end else begin
      popd = (q.size() != 0) && rdy;
      if (en) begin
        m_sum += y;
        m_n++;
        if (m_n == DECIM) begin
          if (q.size() < DEPTH || popd) q.push_back(floor_div(m_sum));
          else m_ovf = 1'b1;
          m_sum = 0;
          m_n   = 0;
        end
      end
      if (popd) void'(q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic block(input int v, input bit rdy);
    for (int i = 0; i < DECIM; i++) cycle(1'b0, 1'b1, v, rdy);
  endtask

  initial begin
    logic signed [DW-1:0] yb;
    @(negedge clk);
    cycle(1'b1, 1'b0, 0, 1'b0);
    check("rst_valid", out_valid, 0);
    check("rst_dec", dec_out, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);

    // Mean of a positive block
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, i, 1'b1);
    check("pos_valid", out_valid, 1);
    check("pos_dec", dec_out, 2);
    cycle(1'b0, 1'b0, 0, 1'b1);
    check("pos_pulse", out_valid, 0);
    check("pos_ovf", overflow, 0);

    // Negative rounding toward -inf
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, -i, 1'b1);
    check("neg_dec", dec_out, -3);
    cycle(1'b0, 1'b0, 0, 1'b1);

    // Extremes
    block(127, 1'b1);
    check("max_dec", dec_out, 127);
    cycle(1'b0, 1'b0, 0, 1'b1);
    block(-128, 1'b1);
    check("min_dec", dec_out, -128);
    cycle(1'b0, 1'b0, 0, 1'b1);
    check("ext_ovf", overflow, 0);

    // Backpressure with a dropped fifth block
    for (int b = 1; b <= 5; b++) block(8 * b, 1'b0);
    check("bp_count", fifo_count, 4);
    check("bp_ovf", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check("bp_drain", dec_out, 8 * (i + 1));
      cycle(1'b0, 1'b0, 0, 1'b1);
    end
    check("bp_empty", out_valid, 0);
    check("bp_ovf_sticky", overflow, 1);

    // Full FIFO with a push and pop in the same cycle
    cycle(1'b1, 1'b0, 0, 1'b0);
    for (int b = 1; b <= 4; b++) block(10 * b, 1'b0);
    check("fp_full", fifo_count, 4);
    for (int i = 0; i < DECIM - 1; i++) cycle(1'b0, 1'b1, 50, 1'b0);
    cycle(1'b0, 1'b1, 50, 1'b1);
    check("fp_count", fifo_count, 4);
    check("fp_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      check("fp_drain", dec_out, 10 * (i + 2));
      cycle(1'b0, 1'b0, 0, 1'b1);
    end
    check("fp_empty", out_valid, 0);

    // Reset mid-block, then a gappy block
    cycle(1'b0, 1'b1, 100, 1'b1);
    cycle(1'b0, 1'b1, 100, 1'b1);
    cycle(1'b1, 1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 8, 1'b0);
      if (i < 3) cycle(1'b0, 1'b0, 77, 1'b0);
    end
    check("gap_valid", out_valid, 1);
    check("gap_dec", dec_out, 8);
    cycle(1'b0, 1'b0, 0, 1'b1);

    // Randomized traffic, including occasional resets
    for (int i = 0; i < 600; i++) begin
      yb = DW'($urandom);
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), int'(yb),
            ($urandom_range(0, 2) == 0));
    end
    check_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
